fwd_hazard_unit: RTL and testbench

Pipeline hazard controller for the 5-stage RISC-V core. It generates the 2-bit operand-select codes consumed by the EX-stage operand muxes and the load-use stall. It tracks destination-register state for the EX, MEM and WB stages in its own shadow pipeline. Forward selects are computed in ID and registered, so they are stable for the whole EX cycle.

---
 rtl/riscv_pkg.sv | 32 +++
 rtl/fwd_src_cmp.sv | 32 +++
 rtl/fwd_hazard_unit.sv | 123 ++++++++++++
 tb/tb_fwd_hazard_unit.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared definitions for the hazard unit: operand-select codes, the shadow
// pipeline stage record and the hazard-source predicate.
package riscv_pkg;

  localparam int REG_AW_DFLT = 5;

  typedef enum logic [1:0] {
    FWD_NONE = 2'b00,
    FWD_WB   = 2'b01,
    FWD_ALU  = 2'b10
  } fwd_sel_t;

  typedef struct packed {
    logic                   valid;
    logic [REG_AW_DFLT-1:0] rd;
    logic                   regwrite;
    logic                   memread;
  } stage_t;

  localparam stage_t STAGE_BUBBLE = '{
    valid:    1'b0,
    rd:       {REG_AW_DFLT{1'b0}},
    regwrite: 1'b0,
    memread:  1'b0
  };

  // x0 is hardwired, so a write to it never produces a value worth forwarding.
  function automatic logic is_hazard_src(input stage_t s);
    return s.valid & s.regwrite & (s.rd != {REG_AW_DFLT{1'b0}});
  endfunction

endpackage

// File: rtl/fwd_src_cmp.sv
// Per-source comparator: next operand select for one ID source plus a flag
// that the source depends on a load still sitting in EX.
module fwd_src_cmp
  import riscv_pkg::*;
(
  input  logic                   use_i,
  input  logic [REG_AW_DFLT-1:0] rs_i,
  input  stage_t                 ex_i,
  input  stage_t                 mem_i,
  output fwd_sel_t               nsel_o,
  output logic                   load_hit_o
);

  logic ex_hit_s;
  logic mem_hit_s;

  // Youngest producer wins; a load in EX cannot supply ALU data yet.
  always_comb begin
    ex_hit_s   = use_i & is_hazard_src(ex_i) & (rs_i == ex_i.rd);
    mem_hit_s  = use_i & is_hazard_src(mem_i) & (rs_i == mem_i.rd);
    load_hit_o = ex_hit_s & ex_i.memread;
    nsel_o     = FWD_NONE;
    if (ex_hit_s && !ex_i.memread) begin
      nsel_o = FWD_ALU;
    end else if (mem_hit_s) begin
      nsel_o = FWD_WB;
    end else begin
      nsel_o = FWD_NONE;
    end
  end

endmodule

// File: rtl/fwd_hazard_unit.sv
// Forwarding select and load-use stall generator with an EX/MEM/WB shadow
// pipeline. Optional event counters are enabled by defining FWD_STATS_EN.
module fwd_hazard_unit
  import riscv_pkg::*;
#(
  parameter int REG_AW = REG_AW_DFLT,
  parameter int XLEN   = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              id_use_rs1,
  input  logic              id_use_rs2,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_regwrite,
  input  logic              id_memread,
  input  logic              ex_flush,
  output logic [1:0]        fwd_a_sel,
  output logic [1:0]        fwd_b_sel,
`ifdef FWD_STATS_EN
  output logic [XLEN-1:0]   stall_cnt,
  output logic [XLEN-1:0]   fwd_cnt,
`endif
  output logic              stall
);

  stage_t   ex_q, mem_q, wb_q, ex_d;
  fwd_sel_t nsel_a_s, nsel_b_s;
  fwd_sel_t fwd_a_q, fwd_b_q;
  logic     load_hit_a_s, load_hit_b_s;
  logic     stall_s;
  logic     wb_unused_s;

  fwd_src_cmp u_cmp_rs1 (
    .use_i      (id_use_rs1),
    .rs_i       (id_rs1),
    .ex_i       (ex_q),
    .mem_i      (mem_q),
    .nsel_o     (nsel_a_s),
    .load_hit_o (load_hit_a_s)
  );

  fwd_src_cmp u_cmp_rs2 (
    .use_i      (id_use_rs2),
    .rs_i       (id_rs2),
    .ex_i       (ex_q),
    .mem_i      (mem_q),
    .nsel_o     (nsel_b_s),
    .load_hit_o (load_hit_b_s)
  );

  assign stall_s     = ~ex_flush & id_valid & (load_hit_a_s | load_hit_b_s);
  assign stall       = stall_s;
  assign fwd_a_sel   = fwd_a_q;
  assign fwd_b_sel   = fwd_b_q;
  // WB record is tracked for completeness; the register file owns the WB bypass.
  assign wb_unused_s = ^wb_q;

  always_comb begin
    ex_d = STAGE_BUBBLE;
    if (ex_flush || stall_s) begin
      ex_d = STAGE_BUBBLE;
    end else begin
      ex_d.valid    = id_valid;
      ex_d.rd       = id_rd;
      ex_d.regwrite = id_regwrite;
      ex_d.memread  = id_memread;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_q  <= STAGE_BUBBLE;
      mem_q <= STAGE_BUBBLE;
      wb_q  <= STAGE_BUBBLE;
    end else begin
      ex_q  <= ex_d;
      mem_q <= ex_q;
      wb_q  <= mem_q;
    end
  end

  // A bubble entering EX must not pick up any forwarded operand.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fwd_a_q <= FWD_NONE;
      fwd_b_q <= FWD_NONE;
    end else if (stall_s || ex_flush) begin
      fwd_a_q <= FWD_NONE;
      fwd_b_q <= FWD_NONE;
    end else begin
      fwd_a_q <= nsel_a_s;
      fwd_b_q <= nsel_b_s;
    end
  end

`ifdef FWD_STATS_EN
  logic [XLEN-1:0] stall_cnt_q, fwd_cnt_q;
  logic [XLEN-1:0] fwd_inc_s;

  always_comb begin
    fwd_inc_s = XLEN'(fwd_a_q != FWD_NONE) + XLEN'(fwd_b_q != FWD_NONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= {XLEN{1'b0}};
      fwd_cnt_q   <= {XLEN{1'b0}};
    end else begin
      stall_cnt_q <= stall_cnt_q + XLEN'(stall_s);
      fwd_cnt_q   <= fwd_cnt_q + fwd_inc_s;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign fwd_cnt   = fwd_cnt_q;
`else
  localparam int XLEN_UNUSED = XLEN;
`endif

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Directed scoreboard bench for fwd_hazard_unit; counter checks apply when
// FWD_STATS_EN is defined.
module tb_fwd_hazard_unit;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       id_valid, id_use_rs1, id_use_rs2, id_regwrite, id_memread, ex_flush;
  logic [4:0] id_rs1, id_rs2, id_rd;
  logic [1:0] fwd_a_sel, fwd_b_sel;
  logic       stall;
`ifdef FWD_STATS_EN
  logic [31:0] stall_cnt, fwd_cnt;
`endif

  typedef struct {
    int         cyc;
    bit         is_sel;
    logic       st;
    logic [1:0] a;
    logic [1:0] b;
    string      nm;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   cyc = 0;
  int   n_vec = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  fwd_hazard_unit dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .id_valid    (id_valid),
    .id_rs1      (id_rs1),
    .id_rs2      (id_rs2),
    .id_use_rs1  (id_use_rs1),
    .id_use_rs2  (id_use_rs2),
    .id_rd       (id_rd),
    .id_regwrite (id_regwrite),
    .id_memread  (id_memread),
    .ex_flush    (ex_flush),
    .fwd_a_sel   (fwd_a_sel),
    .fwd_b_sel   (fwd_b_sel),
`ifdef FWD_STATS_EN
    .stall_cnt   (stall_cnt),
    .fwd_cnt     (fwd_cnt),
`endif
    .stall       (stall)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, req);
    end
  endtask

  // Monitor: pops every expectation due in the current cycle, mid-cycle.
  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      e = sb.pop_front();
      n_vec++;
      if (e.cyc < cyc) begin
        n_fail++;
        $display("FAIL %s: expectation for cycle %0d missed at cycle %0d", e.nm, e.cyc, cyc);
      end else if (e.is_sel) begin
        if (fwd_a_sel !== e.a || fwd_b_sel !== e.b) begin
          n_fail++;
          $display("FAIL %s sel: got a=%b b=%b expected a=%b b=%b", e.nm, fwd_a_sel, fwd_b_sel, e.a, e.b);
        end
      end else if (stall !== e.st) begin
        n_fail++;
        $display("FAIL %s stall: got %b expected %b", e.nm, stall, e.st);
      end
    end
  end

  // One ID-stage instruction per cycle; expected stall now, expected selects next cycle.
  task automatic issue(input string nm, input logic v,
                       input logic [4:0] r1, input logic u1, input logic [4:0] r2, input logic u2,
                       input logic [4:0] rd, input logic rw, input logic mr, input logic fl,
                       input logic es, input logic [1:0] ea, input logic [1:0] eb, input bit chk_sel);
    exp_t x;
    @(posedge clk);
    #1;
    id_valid = v; id_rs1 = r1; id_use_rs1 = u1; id_rs2 = r2; id_use_rs2 = u2;
    id_rd = rd; id_regwrite = rw; id_memread = mr; ex_flush = fl;
    x = '{cyc: cyc, is_sel: 1'b0, st: es, a: 2'b00, b: 2'b00, nm: nm};
    sb.push_back(x);
    if (chk_sel) begin
      x = '{cyc: cyc + 1, is_sel: 1'b1, st: 1'b0, a: ea, b: eb, nm: nm};
      sb.push_back(x);
    end
  endtask

  task automatic idle(input string nm, input logic [1:0] ea, input logic [1:0] eb);
    issue(nm, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, ea, eb, 1'b1);
  endtask

  initial begin
    rst_n = 1'b0;
    id_valid = 1'b0; id_rs1 = 5'd0; id_rs2 = 5'd0; id_use_rs1 = 1'b0; id_use_rs2 = 1'b0;
    id_rd = 5'd0; id_regwrite = 1'b0; id_memread = 1'b0; ex_flush = 1'b0;
    #12;
    chk("reset_stall", 32'(stall), 32'd0);
    chk("reset_sel", {30'd0, fwd_a_sel} | {28'd0, fwd_b_sel, 2'b00}, 32'd0);
`ifdef FWD_STATS_EN
    chk("reset_cnt", stall_cnt | fwd_cnt, 32'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;

    // ALU chain: add x5 ; add x6,x5,x5
    issue("alu_prod",  1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b1);
    issue("alu_chain", 1'b1, 5'd5, 1'b1, 5'd5, 1'b1, 5'd6, 1'b1, 1'b0, 1'b0, 1'b0, 2'b10, 2'b10, 1'b1);
    idle("alu_drain", 2'b00, 2'b00);
    // Distance 2: add x5 ; nop ; sub x7,x1,x5
    issue("d2_prod",   1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b1);
    idle("d2_nop", 2'b00, 2'b00);
    issue("d2_cons",   1'b1, 5'd1, 1'b1, 5'd5, 1'b1, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 1'b1);
    // Load-use: lw x8 ; add x9,x8,x2 (stalls once, then re-issued)
    issue("lu_load",   1'b1, 5'd3, 1'b1, 5'd0, 1'b0, 5'd8, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 1'b1);
    issue("lu_stall",  1'b1, 5'd8, 1'b1, 5'd2, 1'b1, 5'd9, 1'b1, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00, 1'b1);
    issue("lu_retry",  1'b1, 5'd8, 1'b1, 5'd2, 1'b1, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0, 2'b01, 2'b00, 1'b1);
    idle("lu_drain", 2'b00, 2'b00);
`ifdef FWD_STATS_EN
    #4;
    chk("stall_cnt", stall_cnt, 32'd1);
    chk("fwd_cnt", fwd_cnt, 32'd3);
`endif
    // x0 writers never forward
    issue("x0_w1",     1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b1);
    issue("x0_w2",     1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b1);
    issue("x0_read",   1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 5'd10, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b1);
    // Two producers of x3: the younger (EX) wins
    issue("pri_w1",    1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b1);
    issue("pri_w2",    1'b1, 5'd4, 1'b1, 5'd0, 1'b0, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b1);
    issue("pri_read",  1'b1, 5'd3, 1'b1, 5'd3, 1'b1, 5'd11, 1'b1, 1'b0, 1'b0, 1'b0, 2'b10, 2'b10, 1'b1);
    // Flush collides with load-use: no stall, EX becomes a bubble
    issue("fl_load",   1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd12, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 1'b1);
    issue("fl_coll",   1'b1, 5'd12, 1'b1, 5'd12, 1'b1, 5'd13, 1'b1, 1'b0, 1'b1, 1'b0, 2'b00, 2'b00, 1'b1);
    issue("fl_after",  1'b1, 5'd12, 1'b1, 5'd12, 1'b1, 5'd13, 1'b1, 1'b0, 1'b0, 1'b0, 2'b01, 2'b01, 1'b1);
    idle("fl_drain", 2'b00, 2'b00);
    // Async reset during a stall with a live forward select
    issue("rs_load",   1'b1, 5'd13, 1'b1, 5'd0, 1'b0, 5'd14, 1'b1, 1'b1, 1'b0, 1'b0, 2'b01, 2'b00, 1'b1);
    issue("rs_stall",  1'b1, 5'd14, 1'b1, 5'd0, 1'b0, 5'd15, 1'b1, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00, 1'b0);
    #5;
    rst_n = 1'b0;
    #1;
    chk("async_rst_stall", 32'(stall), 32'd0);
    chk("async_rst_sel_a", 32'(fwd_a_sel), 32'd0);
    chk("async_rst_sel_b", 32'(fwd_b_sel), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    // Same consumer after reset: pipeline is empty, so no stall and no forward
    issue("post_rst",  1'b1, 5'd14, 1'b1, 5'd0, 1'b0, 5'd15, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b1);
    idle("post_drain", 2'b00, 2'b00);

    for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
    if (sb.size() > 0) begin
      n_vec++;
      n_fail++;
      $display("FAIL scoreboard_drain: %0d expectations left, expected 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
